// File: rtl/dma_pkg.sv
// Shared types and default sizing for the word-granular DMA copy engine.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } dma_state_e;

  localparam int unsigned DmaAddrW    = 16;
  localparam int unsigned DmaLenW     = 16;
  localparam int unsigned DmaDataW    = 16;
  localparam int unsigned DmaWordStep = 2;

endpackage

// File: rtl/dma_addr_gen.sv
// Source/destination address counters and remaining-word counter for one transfer.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = DmaAddrW,
  parameter int unsigned LEN_W     = DmaLenW,
  parameter int unsigned WORD_STEP = DmaWordStep
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [LEN_W-1:0]  remaining_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  // Address increments wrap naturally at the register width.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    if (load_i) begin
      src_d = src_i;
      dst_d = dst_i;
      rem_d = len_i;
    end else if (step_i) begin
      src_d = src_q + ADDR_W'(WORD_STEP);
      dst_d = dst_q + ADDR_W'(WORD_STEP);
      rem_d = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end

  assign src_o       = src_q;
  assign dst_o       = dst_q;
  assign remaining_o = rem_q;
  assign last_o      = (rem_q == LEN_W'(1));

endmodule

// File: rtl/dma_copy_engine.sv
// Memory-to-memory DMA initiator: read a word, hold it, write it; kill stops bus cycles at once.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = DmaAddrW,
  parameter int unsigned LEN_W     = DmaLenW,
  parameter int unsigned WORD_STEP = DmaWordStep
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [ADDR_W-1:0]   cfg_src_i,
  input  logic [ADDR_W-1:0]   cfg_dst_i,
  input  logic [LEN_W-1:0]    cfg_len_i,
  input  logic                start_i,
  input  logic                kill_i,
  input  logic                dma_ready_i,
  input  logic [DmaDataW-1:0] dma_din_i,
  output logic [ADDR_W-1:0]   dma_addr_o,
  output logic                dma_en_o,
  output logic                dma_we_o,
  output logic [DmaDataW-1:0] dma_dout_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic [LEN_W-1:0]    remaining_o
);

  dma_state_e          state_q, state_d;
  logic [DmaDataW-1:0] data_q, data_d;
  logic                aborted_q, aborted_d;
  logic                load, step, capture, last;
  logic [ADDR_W-1:0]   src, dst;

  dma_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .WORD_STEP(WORD_STEP)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .step_i     (step),
    .src_i      (cfg_src_i),
    .dst_i      (cfg_dst_i),
    .len_i      (cfg_len_i),
    .src_o      (src),
    .dst_o      (dst),
    .remaining_o(remaining_o),
    .last_o     (last)
  );

  // A beat coinciding with kill is neither captured nor counted.
  always_comb begin
    state_d   = state_q;
    aborted_d = aborted_q;
    load      = 1'b0;
    step      = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !kill_i) begin
          aborted_d = 1'b0;
          if (cfg_len_i != '0) begin
            load    = 1'b1;
            state_d = StRd;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRd: begin
        if (kill_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (dma_ready_i) begin
          capture = 1'b1;
          state_d = StWr;
        end
      end
      StWr: begin
        if (kill_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (dma_ready_i) begin
          step    = 1'b1;
          state_d = last ? StDone : StRd;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign data_d = capture ? dma_din_i : data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    dma_addr_o = '0;
    unique case (state_q)
      StRd:    dma_addr_o = src;
      StWr:    dma_addr_o = dst;
      default: dma_addr_o = '0;
    endcase
  end

  assign dma_en_o    = ((state_q == StRd) || (state_q == StWr)) && !kill_i;
  assign dma_we_o    = (state_q == StWr);
  assign dma_dout_o  = data_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign aborted_o   = aborted_q;

endmodule
